// File: rtl/count_display_pkg.sv
// Shared types, constants and the 7-segment decoder for the count display.
package count_display_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } conv_state_t;

  // Active-low segments {g,f,e,d,c,b,a}; all ones turns the digit dark.
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  function automatic logic [6:0] seg7_decode(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = 7'h40;
      4'd1:    seg = 7'h79;
      4'd2:    seg = 7'h24;
      4'd3:    seg = 7'h30;
      4'd4:    seg = 7'h19;
      4'd5:    seg = 7'h12;
      4'd6:    seg = 7'h02;
      4'd7:    seg = 7'h78;
      4'd8:    seg = 7'h00;
      4'd9:    seg = 7'h10;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one bit per SHIFT cycle, then a single
// DONE cycle that publishes the BCD result and pulses conv_done.
module bin2bcd_seq
  import count_display_pkg::*;
#(
  parameter int N      = 8,
  parameter int DIGITS = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [N-1:0]        bin_in,
  output logic                finishing,
  output logic [N-1:0]        bin_latched,
  output logic [4*DIGITS-1:0] bcd_out,
  output logic                conv_done
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(N + 1);

  conv_state_t      state_q, state_d;
  logic [N-1:0]     shift_q, shift_d;
  logic [N-1:0]     src_q, src_d;
  logic [BCD_W-1:0] acc_q, acc_d;
  logic [BCD_W-1:0] bcd_q, bcd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic [BCD_W-1:0] acc_adj;

  // Per-nibble add-3; each nibble is corrected on its own, no carry between them.
  always_comb begin
    acc_adj = acc_q;
    for (int k = 0; k < DIGITS; k++) begin
      if (acc_q[4*k +: 4] >= 4'd5) acc_adj[4*k +: 4] = acc_q[4*k +: 4] + 4'd3;
    end
  end

  // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latch).
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    src_d   = src_q;
    acc_d   = acc_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          shift_d = bin_in;
          src_d   = bin_in;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        {acc_d, shift_d} = {acc_adj, shift_q} << 1;
        cnt_d            = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(N - 1)) state_d = DONE;
      end
      DONE: begin
        bcd_d   = acc_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      src_q   <= '0;
      acc_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      src_q   <= src_d;
      acc_q   <= acc_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign finishing   = (state_q == DONE);
  assign bin_latched = src_q;
  assign bcd_out     = bcd_q;
  assign conv_done   = done_q;

endmodule

// File: rtl/count_display.sv
// Multiplexed common-anode display of the counter value: BCD conversion on
// change, digit scanning with leading-zero blanking, and blinking at zero.
module count_display
  import count_display_pkg::*;
#(
  parameter int N            = 8,
  parameter int DIGITS       = 3,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N-1:0]        value_in,
  input  logic                zero_in,
  output logic [DIGITS-1:0]   an_n,
  output logic [6:0]          seg_n,
  output logic [4*DIGITS-1:0] bcd_out,
  output logic                conv_done
);

  localparam int REF_W = (REFRESH_DIV > 1)  ? $clog2(REFRESH_DIV)  : 1;
  localparam int IDX_W = (DIGITS > 1)       ? $clog2(DIGITS)       : 1;
  localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  if (10**DIGITS <= 2**N - 1) begin : g_bad_digits
    $error("count_display: DIGITS too small to show every N-bit value");
  end
  if (REFRESH_DIV < 2) begin : g_bad_refresh
    $error("count_display: REFRESH_DIV must be at least 2");
  end
  if (BLINK_FRAMES < 1) begin : g_bad_blink
    $error("count_display: BLINK_FRAMES must be at least 1");
  end

  logic                valid_q, valid_d;
  logic [N-1:0]        last_q, last_d;
  logic                conv_start;
  logic                conv_finishing;
  logic [N-1:0]        conv_value;
  logic [4*DIGITS-1:0] bcd_w;

  logic [REF_W-1:0]    refresh_q, refresh_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [FRM_W-1:0]    frame_q, frame_d;
  logic                blink_on_q, blink_on_d;
  logic                frame_end;
  logic [DIGITS-1:0]   an_n_q, an_n_d;
  logic [6:0]          seg_n_q, seg_n_d;
  logic [3:0]          digit_nib;
  logic                digit_blank;

  // Re-convert whenever nothing valid is held or the input moved away from it.
  assign conv_start = !valid_q || (value_in != last_q);

  bin2bcd_seq #(
    .N      (N),
    .DIGITS (DIGITS)
  ) u_bin2bcd (
    .clk         (clk),
    .rst         (rst),
    .start       (conv_start),
    .bin_in      (value_in),
    .finishing   (conv_finishing),
    .bin_latched (conv_value),
    .bcd_out     (bcd_w),
    .conv_done   (conv_done)
  );

  // A digit above the units is dark when it and every higher digit are zero.
  always_comb begin
    digit_nib   = 4'd0;
    digit_blank = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        digit_nib   = bcd_w[4*k +: 4];
        digit_blank = (k != 0) && ((bcd_w >> (4 * k)) == '0);
      end
    end
  end

  always_comb begin
    valid_d    = valid_q;
    last_d     = last_q;
    refresh_d  = refresh_q + REF_W'(1);
    idx_d      = idx_q;
    frame_d    = frame_q;
    blink_on_d = blink_on_q;
    frame_end  = 1'b0;

    if (conv_finishing) begin
      valid_d = 1'b1;
      last_d  = conv_value;
    end

    if (refresh_q == REF_W'(REFRESH_DIV - 1)) begin
      refresh_d = '0;
      if (idx_q == IDX_W'(DIGITS - 1)) begin
        idx_d     = '0;
        frame_end = 1'b1;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end

    // Blink only runs while the count rests at zero; leaving zero restarts it lit.
    if (!zero_in) begin
      frame_d    = '0;
      blink_on_d = 1'b1;
    end else if (frame_end) begin
      if (frame_q == FRM_W'(BLINK_FRAMES - 1)) begin
        frame_d    = '0;
        blink_on_d = !blink_on_q;
      end else begin
        frame_d = frame_q + FRM_W'(1);
      end
    end

    an_n_d  = (zero_in && !blink_on_q) ? '1 : ~(DIGITS'(1) << idx_q);
    seg_n_d = digit_blank ? SEG_BLANK : seg7_decode(digit_nib);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q    <= 1'b0;
      last_q     <= '0;
      refresh_q  <= '0;
      idx_q      <= '0;
      frame_q    <= '0;
      blink_on_q <= 1'b1;
      an_n_q     <= '1;
      seg_n_q    <= SEG_BLANK;
    end else begin
      valid_q    <= valid_d;
      last_q     <= last_d;
      refresh_q  <= refresh_d;
      idx_q      <= idx_d;
      frame_q    <= frame_d;
      blink_on_q <= blink_on_d;
      an_n_q     <= an_n_d;
      seg_n_q    <= seg_n_d;
    end
  end

  assign an_n    = an_n_q;
  assign seg_n   = seg_n_q;
  assign bcd_out = bcd_w;

endmodule

// File: tb/tb_count_display.sv
// Bench for count_display: a cycle model built from the display rules checks
// every output each cycle, and directed scenarios pin literal values.
module tb_count_display;

  localparam int N      = 8;
  localparam int DIGITS = 3;
  localparam int RD     = 4;
  localparam int BF     = 2;
  localparam int FRAME  = RD * DIGITS;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  value_in;
  logic        zero_in;
  logic [2:0]  an_n;
  logic [6:0]  seg_n;
  logic [11:0] bcd_out;
  logic        conv_done;

  always #5 clk = ~clk;

  count_display #(
    .N            (N),
    .DIGITS       (DIGITS),
    .REFRESH_DIV  (RD),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .value_in  (value_in),
    .zero_in   (zero_in),
    .an_n      (an_n),
    .seg_n     (seg_n),
    .bcd_out   (bcd_out),
    .conv_done (conv_done)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [6:0] model_seg(input int d);
    case (d)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
      4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
      8: return 7'h00;  9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic int pow10(input int e);
    int r = 1;
    for (int i = 0; i < e; i++) r = r * 10;
    return r;
  endfunction

  function automatic logic [11:0] to_bcd(input int v);
    return 12'(((v / 100) % 10) * 256 + ((v / 10) % 10) * 16 + (v % 10));
  endfunction

  int          m_cycles = 0;   // rising edges since reset release
  int          m_frames = 0;   // frame ends seen while zero_in held high
  bit          m_valid  = 0;
  int          m_last   = 0;
  bit          m_busy   = 0;
  int          m_left   = 0;
  int          m_src    = 0;
  int          m_disp   = 0;   // number currently shown on bcd_out
  logic [2:0]  e_an   = 3'b111;
  logic [6:0]  e_seg  = 7'h7F;
  logic [11:0] e_bcd  = 12'h000;
  logic        e_done = 1'b0;

  always @(posedge clk) begin
    if (!rst) begin
      m_cycles = 0; m_frames = 0; m_valid = 0; m_last = 0;
      m_busy = 0; m_left = 0; m_src = 0; m_disp = 0;
      e_an = 3'b111; e_seg = 7'h7F; e_bcd = 12'h000; e_done = 1'b0;
    end else begin : model_step
      int  idx;
      bit  off;
      idx   = (m_cycles / RD) % DIGITS;
      off   = zero_in && (((m_frames / BF) % 2) == 1);
      e_an  = off ? 3'b111 : ~(3'b001 << idx);
      if (idx > 0 && m_disp < pow10(idx)) e_seg = 7'h7F;
      else e_seg = model_seg((m_disp / pow10(idx)) % 10);
      e_done = 1'b0;
      if (m_busy) begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 0; m_disp = m_src; m_valid = 1; m_last = m_src; e_done = 1'b1;
        end
      end else if (!m_valid || int'(value_in) != m_last) begin
        m_busy = 1; m_left = N + 1; m_src = int'(value_in);
      end
      e_bcd = to_bcd(m_disp);
      if (!zero_in) m_frames = 0;
      else if ((m_cycles % FRAME) == FRAME - 1) m_frames++;
      m_cycles++;
    end
  end

  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      check("cyc_an_n", an_n, e_an);
      check("cyc_seg_n", seg_n, e_seg);
      check("cyc_bcd_out", bcd_out, e_bcd);
      check("cyc_conv_done", conv_done, e_done);
    end
  end

  // ---------------- directed helpers ----------------
  task automatic wait_done(input string name, input int budget);
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (conv_done === 1'b1) break;
    end
    check({name, "_done"}, conv_done, 1);
  endtask

  task automatic check_digit(input string name, input int d, input logic [6:0] exp_seg);
    logic [2:0] want;
    want = ~(3'b001 << d);
    @(negedge clk);
    for (int k = 0; k < 16; k++) begin
      if (an_n === want) break;
      @(negedge clk);
    end
    check({name, "_an"}, an_n, want);
    check({name, "_seg"}, seg_n, exp_seg);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : directed
    int          pulses;
    logic [11:0] p1, p2;
    logic [2:0]  prev;
    int          run;
    bit          found;

    // 1: reset and first conversion of 0
    rst = 1'b0; value_in = 8'd0; zero_in = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_an_n", an_n, 3'b111);
    check("rst_seg_n", seg_n, 7'h7F);
    check("rst_conv_done", conv_done, 0);
    check("rst_bcd_out", bcd_out, 12'h000);
    rst = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i == 9) check("first_done_early", conv_done, 0);
      if (i == 10) begin
        check("first_done_edge10", conv_done, 1);
        check("first_bcd", bcd_out, 12'h000);
      end
    end

    // 2: full-scale value
    repeat (2) @(negedge clk);
    value_in = 8'd255;
    wait_done("fs", 20);
    check("fs_bcd", bcd_out, 12'h255);
    check_digit("fs_d0", 0, 7'h12);
    check_digit("fs_d1", 1, 7'h12);
    check_digit("fs_d2", 2, 7'h24);

    // 3: leading-zero blanking
    value_in = 8'd7;
    wait_done("v7", 20);
    check("v7_bcd", bcd_out, 12'h007);
    check_digit("v7_d0", 0, 7'h78);
    check_digit("v7_d1", 1, 7'h7F);
    check_digit("v7_d2", 2, 7'h7F);
    value_in = 8'd40;
    wait_done("v40", 20);
    check("v40_bcd", bcd_out, 12'h040);
    check_digit("v40_d0", 0, 7'h40);
    check_digit("v40_d1", 1, 7'h19);
    check_digit("v40_d2", 2, 7'h7F);

    // 4: input changes during the third shift cycle
    repeat (3) @(negedge clk);
    value_in = 8'd100;
    repeat (3) @(negedge clk);
    value_in = 8'd42;
    pulses = 0; p1 = '0; p2 = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (conv_done === 1'b1) begin
        pulses++;
        if (pulses == 1) p1 = bcd_out;
        if (pulses == 2) p2 = bcd_out;
      end
    end
    check("chg_pulses", 32'(pulses), 2);
    check("chg_first", p1, 12'h100);
    check("chg_second", p2, 12'h042);

    // 5: blink while resting at zero
    zero_in = 1'b1; value_in = 8'd0;
    found = 1'b0;
    prev = an_n;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (an_n === 3'b111 && prev !== 3'b111) begin
        found = 1'b1;
        break;
      end
      prev = an_n;
    end
    check("blink_found_off", 32'(found), 1);
    run = 1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (an_n !== 3'b111) break;
      run++;
    end
    check("blink_off_len", 32'(run), 24);
    run = 1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (an_n === 3'b111) break;
      run++;
    end
    check("blink_on_len", 32'(run), 24);
    repeat (3) @(negedge clk);
    check("blink_still_off", an_n, 3'b111);
    zero_in = 1'b0;
    @(negedge clk);
    check("blink_resume", 32'(an_n !== 3'b111), 1);

    // 6: reset in the middle of a conversion
    repeat (5) @(negedge clk);
    value_in = 8'd200;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("midrst_done", conv_done, 0);
      check("midrst_bcd", bcd_out, 12'h000);
    end
    rst = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i == 9) check("rerun_done_early", conv_done, 0);
      if (i == 10) begin
        check("rerun_done", conv_done, 1);
        check("rerun_bcd", bcd_out, 12'h200);
      end
    end
    repeat (4) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
